// File: rtl/spike_frame_packer.sv
// Thresholds a raster pixel stream into spike bits and packs NUM_PIX of them into a frame.
// Double-buffered: a fill buffer streams in while the output buffer waits on the core's handshake.
module spike_frame_packer #(
  parameter int unsigned NUM_PIX = 961,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   thresh,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_last,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [NUM_PIX-1:0] frame_data,
  output logic               frame_err,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int unsigned    IDX_W    = $clog2(NUM_PIX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIX - 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]         state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [NUM_PIX-1:0] fill, fill_n;
  logic [NUM_PIX-1:0] frame_data_n;
  logic               pix_ready_n, frame_valid_n, frame_err_n;
  logic [CNT_W-1:0]   frame_cnt_n, err_cnt_n;
  logic               accept, spike, at_last, out_free;

  // Next-state and next-output logic
  always_comb begin
    accept        = pix_valid && pix_ready;
    spike         = pix_data >= thresh;
    at_last       = idx == IDX_LAST;
    out_free      = !frame_valid || frame_ready;
    state_n       = state;
    idx_n         = idx;
    fill_n        = fill;
    frame_data_n  = frame_data;
    frame_valid_n = frame_valid && !frame_ready;
    frame_err_n   = 1'b0;
    frame_cnt_n   = frame_cnt;
    err_cnt_n     = err_cnt;

    case (state)
      ST_FILL: begin
        if (accept) begin
          fill_n[idx] = spike;
          if (at_last && pix_last) begin
            // Complete frame: hand off now if the output slot frees this cycle, else park it
            if (out_free) begin
              frame_data_n  = fill_n;
              frame_valid_n = 1'b1;
              idx_n         = '0;
              frame_cnt_n   = frame_cnt + CNT_W'(1);
            end else begin
              state_n = ST_FULL;
            end
          end else if (pix_last || at_last) begin
            frame_err_n = 1'b1;
            err_cnt_n   = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
            idx_n       = '0;
            if (!pix_last) state_n = ST_DROP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (frame_valid && frame_ready) begin
          frame_data_n  = fill;
          frame_valid_n = 1'b1;
          frame_cnt_n   = frame_cnt + CNT_W'(1);
          idx_n         = '0;
          state_n       = ST_FILL;
        end
      end
      ST_DROP: begin
        if (accept && pix_last) state_n = ST_FILL;
      end
      default: state_n = ST_FILL;
    endcase

    pix_ready_n = state_n != ST_FULL;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FILL;
      idx         <= '0;
      fill        <= '0;
      pix_ready   <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      fill        <= fill_n;
      pix_ready   <= pix_ready_n;
      frame_valid <= frame_valid_n;
      frame_data  <= frame_data_n;
      frame_err   <= frame_err_n;
      frame_cnt   <= frame_cnt_n;
      err_cnt     <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_spike_frame_packer.sv
// Self-checking bench for spike_frame_packer: directed corner sequences, a threshold table,
// and randomized traffic checked against a frame-level reference model.
module tb_spike_frame_packer;

  localparam int unsigned NUM_PIX = 961;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned CNT_W   = 16;

  typedef struct {
    logic [7:0] d;
    logic [7:0] th;
    logic       sp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PIX_W-1:0]   thresh = '0;
  logic               pix_valid = 1'b0;
  logic               pix_ready;
  logic [PIX_W-1:0]   pix_data = '0;
  logic               pix_last = 1'b0;
  logic               frame_valid;
  logic               frame_ready = 1'b0;
  logic [NUM_PIX-1:0] frame_data;
  logic               frame_err;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   err_cnt;

  spike_frame_packer #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .thresh(thresh),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;
  vec_t tbl [8];

  // Reference model state: frames still owed to the core, the partial frame, error tally
  logic [NUM_PIX-1:0] exp_q [$];
  logic [NUM_PIX-1:0] cur_vec = '0;
  int  cur_len = 0;
  bit  dropping = 1'b0;
  int  exp_frames = 0;
  int  exp_errs = 0;
  int  err_seen = 0;
  bit  rnd = 1'b0;
  bit  win5 = 1'b0;
  int  stall5 = 0;
  int  fv5 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [NUM_PIX-1:0] act,
                           input logic [NUM_PIX-1:0] exp);
    tot++;
    if (act !== exp) begin
      int first = 0;
      for (int i = int'(NUM_PIX) - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      bad++;
      $display("FAIL %s: frame_data bit %0d got %b want %b", nm, first, act[first], exp[first]);
    end
  endtask

  function automatic void model_beat(input logic sp, input logic last);
    if (dropping) begin
      if (last) dropping = 1'b0;
    end else begin
      cur_vec[cur_len] = sp;
      cur_len++;
      if (cur_len == int'(NUM_PIX)) begin
        if (last) begin
          exp_q.push_back(cur_vec);
          exp_frames++;
        end else begin
          exp_errs++;
          dropping = 1'b1;
        end
        cur_len = 0;
      end else if (last) begin
        exp_errs++;
        cur_len = 0;
      end
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cur_len = 0; cur_vec = '0; dropping = 1'b0;
        exp_frames = 0; exp_errs = 0; err_seen = 0;
      end else begin
        chk("valid_vs_model", 32'(frame_valid), 32'(exp_q.size() > 0));
        if (frame_valid && exp_q.size() > 0) begin
          chk_frame("frame_data_model", frame_data, exp_q[0]);
          if (frame_ready) void'(exp_q.pop_front());
        end
        if (frame_err) err_seen++;
        if (win5) begin
          if (pix_valid && !pix_ready) stall5++;
          if (frame_valid) fv5++;
        end
        if (pix_valid && pix_ready) model_beat(pix_data >= thresh, pix_last);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [7:0] th, input logic l);
    int  n = 0;
    bit  acc = 1'b0;
    if (rnd) repeat ($urandom_range(0, 2)) begin
      frame_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b1; pix_data = d; thresh = th; pix_last = l;
    while (!acc) begin
      if (rnd) frame_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 3000) begin
        tot++; bad++;
        $display("FAIL send_beat: pix_ready low for %0d cycles", n);
        $fatal(1, "pixel input stalled");
      end
    end
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_at, input int mode);
    logic [7:0] d, th;
    for (int i = 0; i < len; i++) begin
      th = 8'd128;
      case (mode)
        0: d = 8'(i % 256);
        1: d = 8'hff;
        2: d = 8'h00;
        3: begin d = 8'($urandom); th = 8'($urandom); end
        default: begin d = tbl[i % 8].d; th = tbl[i % 8].th; end
      endcase
      send_beat(d, th, i == last_at);
    end
  endtask

  task automatic checkpoint(input string nm);
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'(16'(exp_frames)));
    chk({nm, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
    chk({nm, "_err_pulses"}, 32'(err_seen), 32'(exp_errs));
  endtask

  initial begin
    logic [NUM_PIX-1:0] exp1;
    tbl[0] = '{8'd0,   8'd0,   1'b1};
    tbl[1] = '{8'd255, 8'd255, 1'b1};
    tbl[2] = '{8'd254, 8'd255, 1'b0};
    tbl[3] = '{8'd128, 8'd128, 1'b1};
    tbl[4] = '{8'd127, 8'd128, 1'b0};
    tbl[5] = '{8'd0,   8'd1,   1'b0};
    tbl[6] = '{8'd255, 8'd0,   1'b1};
    tbl[7] = '{8'd1,   8'd0,   1'b1};
    for (int i = 0; i < int'(NUM_PIX); i++) exp1[i] = ((i % 256) >= 128);

    fork monitor(); join_none

    // Reset state
    #1;
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk_frame("rst_frame_data", frame_data, '0);
    cyc(2);
    rst_n = 1'b1;

    // Ramp frame, output free: valid the cycle after the last beat, one cycle wide
    frame_ready = 1'b1;
    send_frame(NUM_PIX, NUM_PIX - 1, 0);
    chk("t1_latency_valid", 32'(frame_valid), 32'd1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk_frame("t1_frame_data", frame_data, exp1);
    cyc(1);
    chk("t1_valid_falls", 32'(frame_valid), 32'd0);

    // Backpressure: A held while B fills, then B parks in FULL
    frame_ready = 1'b0;
    send_frame(NUM_PIX, NUM_PIX - 1, 1);
    chk("t2_a_valid", 32'(frame_valid), 32'd1);
    send_frame(NUM_PIX, NUM_PIX - 1, 2);
    chk("t2_full_ready", 32'(pix_ready), 32'd0);
    chk_frame("t2_a_held", frame_data, '1);
    cyc(3);
    chk("t2_full_ready_hold", 32'(pix_ready), 32'd0);
    chk("t2_valid_hold", 32'(frame_valid), 32'd1);
    chk_frame("t2_a_still_held", frame_data, '1);
    frame_ready = 1'b1;
    cyc(1);
    chk_frame("t2_b_data", frame_data, '0);
    chk("t2_b_valid", 32'(frame_valid), 32'd1);
    chk("t2_ready_back", 32'(pix_ready), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);
    cyc(1);
    chk("t2_valid_falls", 32'(frame_valid), 32'd0);

    // Short frame
    send_frame(501, 500, 3);
    chk("t3_err_pulse", 32'(frame_err), 32'd1);
    chk("t3_no_valid", 32'(frame_valid), 32'd0);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    cyc(1);
    chk("t3_err_once", 32'(frame_err), 32'd0);
    send_frame(NUM_PIX, NUM_PIX - 1, 3);
    cyc(2);
    checkpoint("t3");
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // Long frame: error at beat 960, remaining beats swallowed
    for (int i = 0; i < 965; i++) begin
      send_beat(8'($urandom), 8'($urandom), i == 964);
      if (i == 960) begin
        chk("t4_err_pulse", 32'(frame_err), 32'd1);
        chk("t4_drop_ready", 32'(pix_ready), 32'd1);
      end
    end
    cyc(2);
    chk("t4_no_valid", 32'(frame_valid), 32'd0);
    chk("t4_err_cnt", 32'(err_cnt), 32'd2);
    send_frame(NUM_PIX, NUM_PIX - 1, 3);
    cyc(2);
    checkpoint("t4");

    // Threshold boundary table, beat i uses entry i%8
    send_frame(NUM_PIX, NUM_PIX - 1, 4);
    chk("tbl_valid", 32'(frame_valid), 32'd1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("tbl_lo_%0d", j), 32'(frame_data[j]), 32'(tbl[j].sp));
      chk($sformatf("tbl_hi_%0d", j), 32'(frame_data[952 + j]), 32'(tbl[j].sp));
    end
    cyc(2);

    // Back-to-back frames with ready tied high
    win5 = 1'b1;
    stall5 = 0; fv5 = 0;
    for (int f = 0; f < 3; f++) send_frame(NUM_PIX, NUM_PIX - 1, 3);
    cyc(2);
    win5 = 1'b0;
    chk("t5_no_stall", 32'(stall5), 32'd0);
    chk("t5_valid_cycles", 32'(fv5), 32'd3);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd9);

    // Randomized traffic: gaps, random backpressure, forced short/long frames
    rnd = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int kind;
      int l;
      kind = (f == 1) ? 0 : (f == 3) ? 1 : int'($urandom_range(0, 9));
      if (kind == 0) l = int'($urandom_range(1, 960));
      else if (kind == 1) l = int'(NUM_PIX) + 1 + int'($urandom_range(0, 4));
      else l = int'(NUM_PIX);
      send_frame(l, l - 1, 3);
    end
    rnd = 1'b0;
    frame_ready = 1'b1;
    cyc(4);
    checkpoint("rand");

    // Reset with a frame held and another partially filled
    frame_ready = 1'b0;
    send_frame(NUM_PIX, NUM_PIX - 1, 3);
    send_frame(300, -1, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_frame_valid", 32'(frame_valid), 32'd0);
    chk("t6_pix_ready", 32'(pix_ready), 32'd0);
    chk("t6_frame_err", 32'(frame_err), 32'd0);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    chk_frame("t6_frame_data", frame_data, '0);
    cyc(2);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    send_frame(NUM_PIX, NUM_PIX - 1, 3);
    chk("t6_after_valid", 32'(frame_valid), 32'd1);
    chk("t6_after_cnt", 32'(frame_cnt), 32'd1);
    cyc(2);
    checkpoint("t6");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
